multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// LEGv8 multicycle control FSM: fetch/decode/exec/mem/wb sequencing,
// memory-wait timeout, sticky trap state and retired-instruction count.
module multicycle_control #(
   parameter int OPCODE_W    = 11,
   parameter int ENABLE_IMM  = 1,
   parameter int MEM_TIMEOUT = 15,
   parameter int RET_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opCode,
   input  logic                mem_ready,
   input  logic                zero,
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                Reg2Loc,
   output logic                ALUSrc,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                Branch,
   output logic                UncondBranch,
   output logic [1:0]          ALUOp,
   output logic [2:0]          state,
   output logic                illegal,
   output logic [RET_W-1:0]    retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      C_NONE  = 4'd0,
      C_LDUR  = 4'd1,
      C_STUR  = 4'd2,
      C_CBZ   = 4'd3,
      C_CBNZ  = 4'd4,
      C_B     = 4'd5,
      C_RTYPE = 4'd6,
      C_IMM   = 4'd7,
      C_ILL   = 4'd8
   } class_t;

   localparam logic [7:0] LP_TO_M1 = 8'(MEM_TIMEOUT - 1);
   localparam logic [RET_W-1:0] LP_ONE = {{(RET_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_next;
   class_t           r_class;
   class_t           w_dec;
   logic [7:0]       r_wait;
   logic [RET_W-1:0] r_retired;
   logic [10:0]      w_op;
   logic             w_wait_hit;
   logic             w_in_wait;
   logic             w_retire;

   assign w_op       = opCode[10:0];
   assign w_in_wait  = (r_state == S_FETCH) || (r_state == S_MEM);
   assign w_wait_hit = (r_wait == LP_TO_M1);

   always_comb begin
      w_dec = C_ILL;
      casez (w_op)
         11'b11111000010: w_dec = C_LDUR;
         11'b11111000000: w_dec = C_STUR;
         11'b10110100???: w_dec = C_CBZ;
         11'b10110101???: w_dec = C_CBNZ;
         11'b000101?????: w_dec = C_B;
         11'b10001011000,
         11'b11001011000,
         11'b10001010000,
         11'b10101010000: w_dec = C_RTYPE;
         11'b1001000100?,
         11'b1101000100?: w_dec = (ENABLE_IMM != 0) ? C_IMM : C_ILL;
         default:         w_dec = C_ILL;
      endcase
   end

   always_comb begin
      w_next       = r_state;
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      Reg2Loc      = 1'b0;
      ALUSrc       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      Branch       = 1'b0;
      UncondBranch = 1'b0;
      ALUOp        = 2'b00;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               w_next  = S_DECODE;
            end else if (w_wait_hit) begin
               w_next = S_TRAP;
            end
         end
         S_DECODE: begin
            w_next = (w_dec == C_ILL) ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            case (r_class)
               C_B: begin
                  UncondBranch = 1'b1;
                  PCWrite      = 1'b1;
                  w_next       = S_FETCH;
               end
               C_CBZ, C_CBNZ: begin
                  Reg2Loc = 1'b1;
                  ALUOp   = 2'b01;
                  Branch  = 1'b1;
                  PCWrite = (r_class == C_CBZ) ? zero : !zero;
                  w_next  = S_FETCH;
               end
               C_RTYPE: begin
                  ALUOp  = 2'b10;
                  w_next = S_WB;
               end
               C_IMM: begin
                  ALUOp  = 2'b11;
                  ALUSrc = 1'b1;
                  w_next = S_WB;
               end
               C_LDUR, C_STUR: begin
                  ALUSrc  = 1'b1;
                  Reg2Loc = (r_class == C_STUR);
                  w_next  = S_MEM;
               end
               default: w_next = S_TRAP;
            endcase
         end
         S_MEM: begin
            ALUSrc = 1'b1;
            if (r_class == C_STUR) begin
               MemWrite = 1'b1;
               Reg2Loc  = 1'b1;
            end else begin
               MemRead = 1'b1;
            end
            if ((r_class != C_STUR) && (r_class != C_LDUR)) begin
               w_next = S_TRAP;
            end else if (mem_ready) begin
               w_next = (r_class == C_LDUR) ? S_WB : S_FETCH;
            end else if (w_wait_hit) begin
               w_next = S_TRAP;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (r_class == C_LDUR);
            w_next   = S_FETCH;
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_TRAP;
      endcase
   end

   // An instruction retires on the edge that returns the FSM to FETCH.
   assign w_retire = (w_next == S_FETCH) &&
                     ((r_state == S_EXEC) ||
                      (r_state == S_MEM)  ||
                      (r_state == S_WB));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_class   <= C_NONE;
         r_wait    <= 8'd0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_class <= w_dec;
         end
         if (w_next != r_state) begin
            r_wait <= 8'd0;
         end else if (w_in_wait && !mem_ready) begin
            r_wait <= r_wait + 8'd1;
         end
         if (w_retire) begin
            r_retired <= r_retired + LP_ONE;
         end
      end
   end

   assign state   = r_state;
   assign illegal = (r_state == S_TRAP);
   assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus random
// instruction streams checked against an instruction-level model.
module tb_multicycle_control;

   localparam int K_LD   = 0;
   localparam int K_ST   = 1;
   localparam int K_CBZ  = 2;
   localparam int K_CBNZ = 3;
   localparam int K_B    = 4;
   localparam int K_R    = 5;
   localparam int K_IMM  = 6;
   localparam int K_ILL  = 7;

   typedef struct packed {
      logic       pcw;
      logic       irw;
      logic       r2l;
      logic       alus;
      logic       m2r;
      logic       rw;
      logic       mr;
      logic       mw;
      logic       br;
      logic       ub;
      logic [1:0] aluop;
      logic       ill;
   } ctl_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] opCode;
   logic        mem_ready;
   logic        zero;

   logic a_pcw, a_irw, a_r2l, a_alus, a_m2r, a_rw;
   logic a_mr, a_mw, a_br, a_ub, a_ill;
   logic [1:0]  a_aluop;
   logic [2:0]  a_state;
   logic [15:0] a_ret;

   logic b_pcw, b_irw, b_r2l, b_alus, b_m2r, b_rw;
   logic b_mr, b_mw, b_br, b_ub, b_ill;
   logic [1:0] b_aluop;
   logic [2:0] b_state;
   logic [2:0] b_ret;

   logic [12:0] a_ctl;
   logic [12:0] b_ctl;

   int n_pass = 0;
   int n_tot  = 0;
   int n_fail = 0;
   int ret_model = 0;
   int ret_b = 0;
   bit chk_b = 1'b0;
   int cls_r;
   logic [10:0] op_r;

   multicycle_control u_dut (
      .clk(clk), .reset(reset), .opCode(opCode),
      .mem_ready(mem_ready), .zero(zero),
      .PCWrite(a_pcw), .IRWrite(a_irw), .Reg2Loc(a_r2l),
      .ALUSrc(a_alus), .MemtoReg(a_m2r), .RegWrite(a_rw),
      .MemRead(a_mr), .MemWrite(a_mw), .Branch(a_br),
      .UncondBranch(a_ub), .ALUOp(a_aluop), .state(a_state),
      .illegal(a_ill), .retired(a_ret)
   );

   multicycle_control #(.ENABLE_IMM(0), .RET_W(3)) u_dut_b (
      .clk(clk), .reset(reset), .opCode(opCode),
      .mem_ready(mem_ready), .zero(zero),
      .PCWrite(b_pcw), .IRWrite(b_irw), .Reg2Loc(b_r2l),
      .ALUSrc(b_alus), .MemtoReg(b_m2r), .RegWrite(b_rw),
      .MemRead(b_mr), .MemWrite(b_mw), .Branch(b_br),
      .UncondBranch(b_ub), .ALUOp(b_aluop), .state(b_state),
      .illegal(b_ill), .retired(b_ret)
   );

   assign a_ctl = {a_pcw, a_irw, a_r2l, a_alus, a_m2r, a_rw,
                   a_mr, a_mw, a_br, a_ub, a_aluop, a_ill};
   assign b_ctl = {b_pcw, b_irw, b_r2l, b_alus, b_m2r, b_rw,
                   b_mr, b_mw, b_br, b_ub, b_aluop, b_ill};

   always #5 clk = ~clk;

   // Expected strobes for a state/class, straight from the control table.
   function automatic logic [12:0] exp_ctl(input int st, input int cls,
                                           input logic rdy, input logic z);
      ctl_t c;
      c = '0;
      case (st)
         0: begin
            c.mr  = 1'b1;
            c.irw = rdy;
            c.pcw = rdy;
         end
         2: begin
            case (cls)
               K_B:    begin c.ub = 1'b1; c.pcw = 1'b1; end
               K_CBZ:  begin c.r2l = 1'b1; c.aluop = 2'b01; c.br = 1'b1; c.pcw = z; end
               K_CBNZ: begin c.r2l = 1'b1; c.aluop = 2'b01; c.br = 1'b1; c.pcw = !z; end
               K_R:    c.aluop = 2'b10;
               K_IMM:  begin c.aluop = 2'b11; c.alus = 1'b1; end
               K_LD:   c.alus = 1'b1;
               K_ST:   begin c.alus = 1'b1; c.r2l = 1'b1; end
               default: ;
            endcase
         end
         3: begin
            c.alus = 1'b1;
            if (cls == K_LD) c.mr = 1'b1;
            else begin c.mw = 1'b1; c.r2l = 1'b1; end
         end
         4: begin
            c.rw  = 1'b1;
            c.m2r = (cls == K_LD);
         end
         5: c.ill = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

   function automatic bit is_legal(input logic [10:0] op);
      casez (op)
         11'b11111000010, 11'b11111000000,
         11'b10110100???, 11'b10110101???,
         11'b000101?????,
         11'b10001011000, 11'b11001011000,
         11'b10001010000, 11'b10101010000,
         11'b1001000100?, 11'b1101000100?: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [10:0] rnd11();
      return 11'($urandom);
   endfunction

   function automatic logic [10:0] mk_op(input int cls);
      logic [10:0] r;
      r = rnd11();
      case (cls)
         K_LD:   return 11'b11111000010;
         K_ST:   return 11'b11111000000;
         K_CBZ:  return {8'b10110100, r[2:0]};
         K_CBNZ: return {8'b10110101, r[2:0]};
         K_B:    return {6'b000101, r[4:0]};
         K_R: begin
            case (r[1:0])
               2'd0:    return 11'b10001011000;
               2'd1:    return 11'b11001011000;
               2'd2:    return 11'b10001010000;
               default: return 11'b10101010000;
            endcase
         end
         K_IMM:  return {(r[0] ? 10'b1101000100 : 10'b1001000100), r[1]};
         default: begin
            while (is_legal(r)) r = rnd11();
            return r;
         end
      endcase
   endfunction

   function automatic int bs(input int st);
      return chk_b ? st : -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (fail #%0d)",
                tag, obs, exp, n_fail);
      end
   endtask

   // One clock: drive inputs on the falling edge, check just after.
   task automatic step(input int st, input int cls, input logic rdy,
                       input logic z, input logic [10:0] op,
                       input int stb);
      @(negedge clk);
      reset     = 1'b0;
      opCode    = op;
      mem_ready = rdy;
      zero      = z;
      #1;
      chk("state", 32'(a_state), 32'(st));
      chk("ctl", 32'(a_ctl), 32'(exp_ctl(st, cls, rdy, z)));
      chk("retired", 32'(a_ret), 32'(ret_model));
      if (stb >= 0) begin
         chk("b_state", 32'(b_state), 32'(stb));
         chk("b_ctl", 32'(b_ctl), 32'(exp_ctl(stb, cls, rdy, z)));
         chk("b_retired", 32'(b_ret), 32'(ret_b % 8));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      mem_ready = 1'b0;
      ret_model = 0;
      ret_b     = 0;
   endtask

   // Instruction-level model: fd/md = not-ready cycles in FETCH/MEM.
   task automatic run_instr(input logic [10:0] op, input int cls,
                            input int fd, input int md, input logic z);
      for (int i = 0; i <= fd; i++)
         step(0, cls, (i == fd), z, rnd11(), bs(0));
      step(1, cls, 1'($urandom), z, op, bs(1));
      if (cls == K_ILL) begin
         step(5, cls, 1'($urandom), z, rnd11(), bs(5));
         return;
      end
      step(2, cls, 1'($urandom), z, rnd11(), bs(2));
      if (cls == K_LD || cls == K_ST)
         for (int i = 0; i <= md; i++)
            step(3, cls, (i == md), z, rnd11(), bs(3));
      if (cls == K_LD || cls == K_R || cls == K_IMM)
         step(4, cls, 1'($urandom), z, rnd11(), bs(4));
      ret_model++;
      ret_b++;
   endtask

   initial begin
      reset     = 1'b1;
      opCode    = '0;
      mem_ready = 1'b0;
      zero      = 1'b0;
      repeat (2) @(negedge clk);

      run_instr(11'b10001011000, K_R, 0, 0, 1'b0);
      run_instr(11'b11111000010, K_LD, 0, 3, 1'b0);
      run_instr(mk_op(K_CBZ), K_CBZ, 1, 0, 1'b1);
      run_instr(mk_op(K_CBNZ), K_CBNZ, 0, 0, 1'b1);
      run_instr(mk_op(K_ST), K_ST, 2, 2, 1'b0);

      do_reset();
      for (int i = 0; i < 15; i++) step(0, K_LD, 1'b0, 1'b0, rnd11(), -1);
      step(5, K_ILL, 1'b0, 1'b0, rnd11(), -1);
      step(5, K_ILL, 1'b1, 1'b0, rnd11(), -1);
      do_reset();
      run_instr(11'b10001011000, K_R, 14, 0, 1'b0);

      do_reset();
      step(0, K_LD, 1'b1, 1'b0, rnd11(), -1);
      step(1, K_LD, 1'b0, 1'b0, 11'b11111000010, -1);
      step(2, K_LD, 1'b0, 1'b0, rnd11(), -1);
      for (int i = 0; i < 15; i++) step(3, K_LD, 1'b0, 1'b0, rnd11(), -1);
      step(5, K_ILL, 1'b1, 1'b0, rnd11(), -1);

      do_reset();
      op_r = mk_op(K_IMM);
      step(0, K_IMM, 1'b1, 1'b0, rnd11(), 0);
      step(1, K_IMM, 1'b0, 1'b0, op_r, 1);
      step(2, K_IMM, 1'b0, 1'b0, rnd11(), 5);
      step(4, K_IMM, 1'b0, 1'b0, rnd11(), 5);
      ret_model++;
      step(0, K_IMM, 1'b0, 1'b0, rnd11(), 5);
      step(0, K_IMM, 1'b0, 1'b0, rnd11(), 5);

      do_reset();
      run_instr(mk_op(K_B), K_B, 0, 0, 1'b0);
      step(0, K_ST, 1'b1, 1'b0, rnd11(), -1);
      step(1, K_ST, 1'b0, 1'b0, 11'b11111000000, -1);
      step(2, K_ST, 1'b0, 1'b0, rnd11(), -1);
      step(3, K_ST, 1'b0, 1'b0, rnd11(), -1);
      do_reset();
      step(0, K_ST, 1'b0, 1'b0, rnd11(), -1);

      do_reset();
      for (int n = 0; n < 30; n++) begin
         cls_r = $urandom_range(0, 7);
         run_instr(mk_op(cls_r), cls_r, $urandom_range(0, 4),
                   $urandom_range(0, 4), 1'($urandom));
         if (cls_r == K_ILL) begin
            step(5, K_ILL, 1'b1, 1'b0, rnd11(), -1);
            do_reset();
         end
      end

      do_reset();
      chk_b = 1'b1;
      for (int n = 0; n < 12; n++) begin
         cls_r = $urandom_range(0, 5);
         run_instr(mk_op(cls_r), cls_r, $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom));
      end
      chk_b = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
